// File: rtl/button_conditioner.sv
// button_conditioner: synchronize, debounce and edge-detect active-low push buttons, with optional auto-repeat step pulses
//   clock_i    system clock, all state updates on its rising edge
//   reset_i    synchronous active-high reset
//   button_n_i raw asynchronous buttons, 0 = pressed
//   level_o    debounced level, 1 = pressed
//   press_o    one-cycle pulse when level rises
//   release_o  one-cycle pulse when level falls
//   step_o     one-cycle pulse on each press and each auto-repeat tick
module button_conditioner #(
  parameter int           N             = 3,
  parameter int           DEBOUNCE      = 16,
  parameter int           REPEAT_DELAY  = 64,
  parameter int           REPEAT_PERIOD = 16,
  parameter logic [N-1:0] REPEAT_EN     = '0
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic [N-1:0] button_n_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] step_o
);
  localparam int DW   = $clog2(DEBOUNCE + 1);
  localparam int HMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);
  typedef enum logic [1:0] {RELEASED, HOLD, REPEAT} state_e;
  logic [N-1:0] s1_q, s2_q, raw_p;
  // Synchronizers reset to the released state so a button held through reset reads as a new press.
  always_ff @(posedge clock_i) begin
    s1_q <= reset_i ? '1 : button_n_i;
    s2_q <= reset_i ? '1 : s1_q;
  end
  assign raw_p = ~s2_q;
  for (genvar g = 0; g < N; g++) begin : g_btn
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q;
    logic          level_q, level_d, flip, rise, fall;
    logic          press_q, release_q, step_q;
    state_e        state_q;
    // The counter only advances while raw disagrees with level, so it never exceeds DEBOUNCE-1.
    always_comb begin
      flip    = raw_p[g] != level_q && dcnt_q == DW'(DEBOUNCE - 1);
      dcnt_d  = (raw_p[g] == level_q || flip) ? '0 : dcnt_q + 1'b1;
      level_d = level_q ^ flip;
      rise    = level_d & ~level_q;
      fall    = ~level_d & level_q;
    end
    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        dcnt_q    <= '0;
        hcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        step_q    <= 1'b0;
        state_q   <= RELEASED;
      end else begin
        dcnt_q    <= dcnt_d;
        level_q   <= level_d;
        press_q   <= rise;
        release_q <= fall;
        step_q    <= 1'b0;
        unique case (state_q)
          RELEASED: if (rise) begin
            state_q <= HOLD;
            hcnt_q  <= '0;
            step_q  <= 1'b1;
          end
          HOLD: if (fall) state_q <= RELEASED;
          else if (REPEAT_EN[g] && hcnt_q == HW'(REPEAT_DELAY - 1)) begin
            state_q <= REPEAT;
            hcnt_q  <= '0;
            step_q  <= 1'b1;
          end else hcnt_q <= &hcnt_q ? hcnt_q : hcnt_q + 1'b1;
          REPEAT: if (fall) state_q <= RELEASED;
          else if (hcnt_q == HW'(REPEAT_PERIOD - 1)) begin
            hcnt_q <= '0;
            step_q <= 1'b1;
          end else hcnt_q <= &hcnt_q ? hcnt_q : hcnt_q + 1'b1;
          default: state_q <= RELEASED;
        endcase
      end
    end
    assign level_o[g]   = level_q;
    assign press_o[g]   = press_q;
    assign release_o[g] = release_q;
    assign step_o[g]    = step_q;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner
module tb_button_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] button_n = '0;
  logic [2:0] level, press, rel, step;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {int cyc; int val;} ev_t;
  ev_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  button_conditioner #(
    .N(3), .DEBOUNCE(16), .REPEAT_DELAY(64), .REPEAT_PERIOD(16), .REPEAT_EN(3'b001)
  ) dut (
    .clock_i(clk), .reset_i(reset), .button_n_i(button_n),
    .level_o(level), .press_o(press), .release_o(rel), .step_o(step)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int pk(input logic [2:0] s, input logic [2:0] r, input logic [2:0] p);
    return int'({s, r, p});
  endfunction
  task automatic expect_at(input int t, input int v);
    sb.push_back('{t, v});
  endtask
  task automatic at(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  always @(negedge clk) begin : mon
    int obs;
    obs = int'({step, rel, press});
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("missed_pulse", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (obs != 0) begin
      if (sb.size() == 0 || sb[0].cyc != cyc) chk("spurious_pulse", obs, 0);
      else chk("pulse_val", obs, sb.pop_front().val);
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int t, r;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs", int'({level, press, rel, step}), 0);
    end
    reset = 1'b0;
    t = cyc + 18;
    expect_at(t, pk(3'b111, 3'b000, 3'b111));
    at(t - 1);
    chk("rst_lvl_pre", int'(level), 0);
    at(t);
    chk("rst_lvl", int'(level), 7);
    at(t + 1);
    chk("press_once", int'(press), 0);
    button_n = 3'b111;
    t = cyc + 18;
    expect_at(t, pk(3'b000, 3'b111, 3'b000));
    at(t - 1);
    chk("rel_lvl_pre", int'(level), 7);
    at(t);
    chk("rel_lvl", int'(level), 0);
    for (int k = 0; k < 12; k++) begin
      button_n[0] = k[0];
      repeat (5) @(negedge clk);
      chk("bounce_lvl", int'(level), 0);
    end
    button_n[0] = 1'b0;
    t = cyc + 18;
    expect_at(t, pk(3'b001, 3'b000, 3'b001));
    at(t - 1);
    chk("bounce_lvl_pre", int'(level), 0);
    at(t);
    chk("bounce_lvl", int'(level), 1);
    r = t;
    for (int d = 64; d < 200; d += 16) expect_at(r + d, pk(3'b001, 3'b000, 3'b000));
    at(r + 182);
    button_n[0] = 1'b1;
    expect_at(r + 200, pk(3'b000, 3'b001, 3'b000));
    at(r + 199);
    chk("rep_lvl_held", int'(level), 1);
    at(r + 200);
    chk("rep_lvl_rel", int'(level), 0);
    at(r + 300);
    button_n[2] = 1'b0;
    t = cyc + 18;
    expect_at(t, pk(3'b100, 3'b000, 3'b100));
    at(t + 182);
    button_n[2] = 1'b1;
    expect_at(t + 200, pk(3'b000, 3'b100, 3'b000));
    at(t + 190);
    chk("norep_lvl", int'(level), 4);
    at(t + 300);
    button_n[0] = 1'b0;
    r = cyc + 18;
    expect_at(r, pk(3'b001, 3'b000, 3'b001));
    expect_at(r + 64, pk(3'b001, 3'b000, 3'b000));
    expect_at(r + 80, pk(3'b001, 3'b000, 3'b000));
    at(r + 90);
    reset = 1'b1;
    at(r + 91);
    chk("midrst_out1", int'({level, press, rel, step}), 0);
    at(r + 92);
    chk("midrst_out2", int'({level, press, rel, step}), 0);
    reset = 1'b0;
    t = cyc + 18;
    expect_at(t, pk(3'b001, 3'b000, 3'b001));
    at(t - 1);
    chk("midrst_lvl_pre", int'(level), 0);
    at(t);
    chk("midrst_lvl", int'(level), 1);
    at(t + 2);
    button_n[0] = 1'b1;
    expect_at(t + 20, pk(3'b000, 3'b001, 3'b000));
    at(t + 120);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
